// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store controller with misaligned byte splitting
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned accesses instead of splitting them).
module load_store_unit #(
    parameter int         ADDR_BITS = 20,
    parameter logic [1:0] IDLE_SIZE = 2'b11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_data_size,
    output logic        mem_data_unsigned,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] ea_q;
    logic [ADDR_BITS-1:0] mem_addr_q;
    logic [1:0]           size_q;
    logic [1:0]           idx_q;
    logic [1:0]           last_idx_q;
    logic [1:0]           mem_size_q;
    logic                 unsigned_q;
    logic                 write_q;
    logic                 req_ready_q;
    logic                 resp_valid_q;
    logic                 misaligned_q;
    logic                 mem_unsigned_q;
    logic                 mem_we_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic [31:0]          mem_wdata_q;

    logic [ADDR_BITS-1:0] ea_d;
    logic [ADDR_BITS-1:0] split_addr_d;
    logic                 aligned_d;
    logic [1:0]           idx_d;
    logic [7:0]           wbyte_d;
    logic [31:0]          assembled_d;
    logic [31:0]          extended_d;

    always_comb begin
        ea_d = ADDR_BITS'(req_base + req_offset);
        case (req_size)
            2'b01:   aligned_d = ~ea_d[0];
            2'b10:   aligned_d = (ea_d[1:0] == 2'b00);
            default: aligned_d = 1'b1;
        endcase
    end

    // Split bookkeeping: the next byte's address/data, and the load word with this cycle's byte merged in.
    always_comb begin
        idx_d        = idx_q + 2'd1;
        split_addr_d = ea_q + ADDR_BITS'(idx_d);
        wbyte_d      = wdata_q[{idx_d, 3'b000} +: 8];
        assembled_d  = rdata_q;
        assembled_d[{idx_q, 3'b000} +: 8] = mem_read_data[7:0];
        if (size_q == 2'b01) begin
            extended_d = unsigned_q ? {16'h0, assembled_d[15:0]}
                                    : {{16{assembled_d[15]}}, assembled_d[15:0]};
        end else begin
            extended_d = assembled_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            ea_q           <= '0;
            mem_addr_q     <= '0;
            size_q         <= 2'b00;
            idx_q          <= 2'b00;
            last_idx_q     <= 2'b00;
            mem_size_q     <= IDLE_SIZE;
            unsigned_q     <= 1'b0;
            write_q        <= 1'b0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            misaligned_q   <= 1'b0;
            mem_unsigned_q <= 1'b1;
            mem_we_q       <= 1'b0;
            wdata_q        <= 32'h0;
            rdata_q        <= 32'h0;
            mem_wdata_q    <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        ea_q         <= ea_d;
                        size_q       <= req_size;
                        unsigned_q   <= req_unsigned;
                        write_q      <= req_write;
                        wdata_q      <= req_wdata;
                        req_ready_q  <= 1'b0;
                        rdata_q      <= 32'h0;
                        misaligned_q <= 1'b0;
                        if (req_size == 2'b11) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                        end else if (aligned_d) begin
                            state_q        <= S_ACCESS;
                            mem_addr_q     <= ea_d;
                            mem_size_q     <= req_size;
                            mem_unsigned_q <= req_unsigned;
                            mem_wdata_q    <= req_wdata;
                            mem_we_q       <= req_write;
                        end else begin
`ifdef LSU_MISALIGN_TRAP_EN
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            misaligned_q <= 1'b1;
`else
                            state_q        <= S_SPLIT;
                            idx_q          <= 2'b00;
                            last_idx_q     <= (req_size == 2'b01) ? 2'd1 : 2'd3;
                            mem_addr_q     <= ea_d;
                            mem_size_q     <= 2'b00;
                            mem_unsigned_q <= 1'b1;
                            mem_wdata_q    <= {24'h0, req_wdata[7:0]};
                            mem_we_q       <= req_write;
`endif
                        end
                    end
                end
                S_ACCESS: begin
                    state_q        <= S_RESP;
                    resp_valid_q   <= 1'b1;
                    rdata_q        <= write_q ? 32'h0 : mem_read_data;
                    mem_we_q       <= 1'b0;
                    mem_size_q     <= IDLE_SIZE;
                    mem_addr_q     <= '0;
                    mem_wdata_q    <= 32'h0;
                    mem_unsigned_q <= 1'b1;
                end
                S_SPLIT: begin
                    if (idx_q == last_idx_q) begin
                        state_q        <= S_RESP;
                        resp_valid_q   <= 1'b1;
                        rdata_q        <= write_q ? 32'h0 : extended_d;
                        mem_we_q       <= 1'b0;
                        mem_size_q     <= IDLE_SIZE;
                        mem_addr_q     <= '0;
                        mem_wdata_q    <= 32'h0;
                        mem_unsigned_q <= 1'b1;
                    end else begin
                        idx_q       <= idx_d;
                        rdata_q     <= assembled_d;
                        mem_addr_q  <= split_addr_d;
                        mem_wdata_q <= {24'h0, wbyte_d};
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_rdata        = rdata_q;
    assign resp_misaligned   = misaligned_q;
    assign mem_address       = {{(32-ADDR_BITS){1'b0}}, mem_addr_q};
    assign mem_write_data    = mem_wdata_q;
    assign mem_data_size     = mem_size_q;
    assign mem_data_unsigned = mem_unsigned_q;
    // A reset arriving mid-split must not let the in-flight byte reach memory at the reset edge.
    assign mem_write_enable  = mem_we_q & rst_n;

endmodule
